// File: rtl/serial_slave_port.sv
// Serial-bus slave responder: deserialises address and write data, accesses a
// local byte memory, and serialises read data back LSB first.
module serial_slave_port #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 8,
   parameter int MEM_AW = 11
) (
   input  logic clk,
   input  logic reset,
   input  logic valid_in,
   input  logic wr_en,
   input  logic address_in,
   input  logic data_in,
   output logic ready,
   output logic valid_out,
   output logic data_out,
   output logic err
);

   localparam int MAXW = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
   localparam int CW   = (MAXW > 1) ? $clog2(MAXW) : 1;

   typedef enum logic [2:0] {IDLE, ADDR, WDATA, WRITE, RLOAD, RSEND} state_t;

   state_t              state;
   logic [CW-1:0]       cnt;
   logic [MEM_AW-1:0]   addr;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W-1:0]   tx;
   logic                wr_lat;
   logic [DATA_W-1:0]   mem [2**MEM_AW];

   // Memory is deliberately not reset; a reset during WRITE moves state away
   // before the next edge, so the pending write never lands.
   always_ff @(posedge clk) begin
      if (state == WRITE)
         mem[addr] <= wdata;
   end

   // Only the low MEM_AW address bits are kept; higher bits alias and are
   // simply not shifted in.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         addr      <= '0;
         wdata     <= '0;
         tx        <= '0;
         wr_lat    <= 1'b0;
         ready     <= 1'b1;
         valid_out <= 1'b0;
         data_out  <= 1'b0;
         err       <= 1'b0;
      end else begin
         err <= 1'b0;
         case (state)
            IDLE: begin
               if (valid_in) begin
                  addr   <= {address_in, addr[MEM_AW-1:1]};
                  wr_lat <= wr_en;
                  cnt    <= '0;
                  ready  <= 1'b0;
                  state  <= ADDR;
               end
            end
            ADDR: begin
               if (!valid_in) begin
                  state <= IDLE;
                  ready <= 1'b1;
                  err   <= 1'b1;
                  cnt   <= '0;
               end else begin
                  if (int'(cnt) < MEM_AW - 1)
                     addr <= {address_in, addr[MEM_AW-1:1]};
                  if (int'(cnt) == ADDR_W - 2) begin
                     cnt   <= '0;
                     state <= wr_lat ? WDATA : RLOAD;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            WDATA: begin
               if (!valid_in) begin
                  state <= IDLE;
                  ready <= 1'b1;
                  err   <= 1'b1;
                  cnt   <= '0;
               end else begin
                  wdata <= {data_in, wdata[DATA_W-1:1]};
                  if (int'(cnt) == DATA_W - 1) begin
                     cnt   <= '0;
                     state <= WRITE;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            WRITE: begin
               state <= IDLE;
               ready <= 1'b1;
               cnt   <= '0;
            end
            // data_out always mirrors tx[0], so it is preloaded with bit 0 here
            RLOAD: begin
               tx        <= mem[addr];
               data_out  <= mem[addr][0];
               valid_out <= 1'b1;
               cnt       <= '0;
               state     <= RSEND;
            end
            RSEND: begin
               tx <= {1'b0, tx[DATA_W-1:1]};
               if (int'(cnt) == DATA_W - 1) begin
                  state     <= IDLE;
                  ready     <= 1'b1;
                  valid_out <= 1'b0;
                  data_out  <= 1'b0;
                  cnt       <= '0;
               end else begin
                  data_out <= tx[1];
                  cnt      <= cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               ready <= 1'b1;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_slave_port.sv
// Self-checking bench for serial_slave_port: directed scenarios plus random
// traffic against a byte-array model of the aliased local memory.
module tb_serial_slave_port;

   logic clk = 1'b0;
   logic reset, valid_in, wr_en, address_in, data_in;
   logic ready, valid_out, data_out, err;

   int total = 0;
   int bad   = 0;

   logic [7:0] model [int];
   int         written [$];

   serial_slave_port dut (
      .clk        (clk),
      .reset      (reset),
      .valid_in   (valid_in),
      .wr_en      (wr_en),
      .address_in (address_in),
      .data_in    (data_in),
      .ready      (ready),
      .valid_out  (valid_out),
      .data_out   (data_out),
      .err        (err)
   );

   always #5 clk = ~clk;

   // Drives T0..T11; ok collects ready=1 at T0 and ready=0 during T1..T11.
   task automatic start_addr(input logic we, input logic [11:0] a, output logic ok);
      ok = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (i == 0) ok &= ready;
         else        ok &= !ready;
         valid_in   = 1'b1;
         wr_en      = (i == 0) ? we : ~we;
         address_in = a[i];
         data_in    = 1'($urandom);
      end
   endtask

   task automatic send_data(input logic [7:0] d, inout logic ok);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         ok &= !ready;
         valid_in   = 1'b1;
         data_in    = d[i];
         address_in = 1'($urandom);
         wr_en      = 1'($urandom);
      end
   endtask

   // Returns after the T20 drive; the next negedge is T21.
   task automatic do_write(input logic [11:0] a, input logic [7:0] d, output logic ok);
      start_addr(1'b1, a, ok);
      send_data(d, ok);
      @(negedge clk);
      ok &= !ready;
      valid_in = 1'b0;
      model[int'(a[10:0])] = d;
      written.push_back(int'(a[10:0]));
   endtask

   task automatic do_read(input logic [11:0] a, output logic [7:0] rd, output logic ok);
      start_addr(1'b0, a, ok);
      @(negedge clk);
      ok &= !valid_out & !ready;
      valid_in = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         ok &= valid_out & !ready;
         rd[i] = data_out;
      end
   endtask

   task automatic test_reset;
      reset = 1'b0; valid_in = 1'b0; wr_en = 1'b0; address_in = 1'b0; data_in = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if ({ready, valid_out, data_out, err} !== 4'b1000) begin
         bad++;
         $display("[TB] FAIL reset_hold: got %b need 1000", {ready, valid_out, data_out, err});
      end
      reset = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         total++;
         if ({ready, valid_out, data_out, err} !== 4'b1000) begin
            bad++;
            $display("[TB] FAIL idle_%0d: got %b need 1000", i, {ready, valid_out, data_out, err});
         end
      end
   endtask

   task automatic test_write_read;
      logic ok; logic [7:0] rd;
      do_write(12'h005, 8'hA5, ok);
      total++;
      if (ok !== 1'b1) begin bad++; $display("[TB] FAIL wr_timing: got %b need 1", ok); end
      do_read(12'h005, rd, ok);
      total++;
      if (ok !== 1'b1) begin bad++; $display("[TB] FAIL rd_timing: got %b need 1", ok); end
      total++;
      if (rd !== 8'hA5) begin bad++; $display("[TB] FAIL rd_a5: got %h need a5", rd); end
      @(negedge clk);
      total++;
      if ({ready, valid_out} !== 2'b10) begin
         bad++;
         $display("[TB] FAIL rd_end: got %b need 10", {ready, valid_out});
      end
   endtask

   task automatic test_alias;
      logic ok; logic [7:0] rd;
      do_write(12'h805, 8'h3C, ok);
      do_read(12'h005, rd, ok);
      total++;
      if (rd !== 8'h3C || ok !== 1'b1) begin
         bad++;
         $display("[TB] FAIL alias: got %h ok=%b need 3c ok=1", rd, ok);
      end
   endtask

   task automatic test_abort;
      logic ok; logic [7:0] rd;
      logic [11:0] a;
      a = 12'h010;
      do_write(a, 8'h42, ok);
      for (int i = 0; i <= 6; i++) begin
         @(negedge clk);
         valid_in   = (i < 6);
         wr_en      = 1'b1;
         address_in = a[i];
         data_in    = 1'b1;
      end
      @(negedge clk);
      valid_in = 1'b0;
      total++;
      if ({err, ready} !== 2'b11) begin
         bad++;
         $display("[TB] FAIL abort_err: got %b need 11", {err, ready});
      end
      @(negedge clk);
      total++;
      if (err !== 1'b0) begin bad++; $display("[TB] FAIL abort_pulse: got %b need 0", err); end
      do_read(a, rd, ok);
      total++;
      if (rd !== model[16] || ok !== 1'b1) begin
         bad++;
         $display("[TB] FAIL abort_mem: got %h need %h", rd, model[16]);
      end
   endtask

   task automatic test_back_to_back;
      logic ok; logic [7:0] rd;
      do_write(12'h001, 8'h11, ok);
      do_read(12'h001, rd, ok);
      total++;
      if (rd !== 8'h11 || ok !== 1'b1) begin
         bad++;
         $display("[TB] FAIL b2b: got %h ok=%b need 11 ok=1", rd, ok);
      end
   endtask

   task automatic test_reset_rsend;
      logic ok; logic [7:0] rd, d;
      d = 8'($urandom);
      do_write(12'h123, d, ok);
      start_addr(1'b0, 12'h123, ok);
      @(negedge clk);
      valid_in = 1'b0;
      repeat (4) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      total++;
      if ({ready, valid_out, err} !== 3'b100) begin
         bad++;
         $display("[TB] FAIL rst_rsend: got %b need 100", {ready, valid_out, err});
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      total++;
      if (ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_ready: got %b need 1", ready); end
      do_read(12'h123, rd, ok);
      total++;
      if (rd !== d || ok !== 1'b1) begin
         bad++;
         $display("[TB] FAIL rst_reread: got %h need %h", rd, d);
      end
   endtask

   task automatic test_reset_write;
      logic ok; logic [7:0] rd;
      do_write(12'h2A7, 8'h77, ok);
      start_addr(1'b1, 12'h2A7, ok);
      send_data(8'h88, ok);
      @(negedge clk);
      valid_in = 1'b0;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      do_read(12'h2A7, rd, ok);
      total++;
      if (rd !== 8'h77) begin bad++; $display("[TB] FAIL rst_write_lost: got %h need 77", rd); end
   endtask

   task automatic test_random;
      logic ok; logic [7:0] rd, d;
      logic [11:0] a;
      int k;
      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 2))
            0: begin
               a = 12'($urandom); d = 8'($urandom);
               do_write(a, d, ok);
               total++;
               if (ok !== 1'b1) begin bad++; $display("[TB] FAIL rnd_wr_timing_%0d: got %b need 1", n, ok); end
            end
            1: begin
               a = 12'(written[$urandom_range(0, written.size() - 1)]);
               a[11] = 1'($urandom);
               do_read(a, rd, ok);
               total++;
               if (rd !== model[int'(a[10:0])] || ok !== 1'b1) begin
                  bad++;
                  $display("[TB] FAIL rnd_rd_%0d: addr %h got %h ok=%b need %h", n, a, rd, ok, model[int'(a[10:0])]);
               end
            end
            default: begin
               a = 12'($urandom); d = 8'($urandom);
               k = $urandom_range(1, 19);
               for (int i = 0; i <= k; i++) begin
                  @(negedge clk);
                  valid_in   = (i < k);
                  wr_en      = (i == 0) ? 1'b1 : 1'($urandom);
                  address_in = (i < 12) ? a[i] : 1'($urandom);
                  data_in    = (i >= 12) ? d[i-12] : 1'($urandom);
               end
               @(negedge clk);
               valid_in = 1'b0;
               total++;
               if ({err, ready} !== 2'b11) begin
                  bad++;
                  $display("[TB] FAIL rnd_abort_%0d: at bit %0d got %b need 11", n, k, {err, ready});
               end
            end
         endcase
      end
   endtask

   initial begin
      test_reset;
      test_write_read;
      test_alias;
      test_abort;
      test_back_to_back;
      test_reset_rsend;
      test_reset_write;
      test_random;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/serial_slave_port.md
# serial_slave_port

Bus-side responder for one memory slave on the serial address/data bus. It deserialises the bit-serial address and write data coming from the arbiter's slave-side port, performs the access on a local byte memory, and serialises read data back to the arbiter. It drives the slave's ready, read-valid and read-data lines, so it can be dropped in wherever a slave instance sits under the top level.

## Interface
- ADDR_W, 12, serial address length in bits, transmitted LSB first.
- DATA_W, 8, data word width in bits, transmitted LSB first.
- MEM_AW, 11, local memory index width; depth is 2^MEM_AW words; MEM_AW ≤ ADDR_W.

- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- valid_in  input  1  arbiter strobe; high while address or write-data bits are on the bus.
- wr_en  input  1  1 = write, 0 = read; sampled only in the start cycle.
- address_in  input  1  serial address bit.
- data_in  input  1  serial write-data bit.
- ready  output  1  high only in IDLE; arbiter may start a transaction only while high.
- valid_out  output  1  high while a read-data bit is on data_out.
- data_out  output  1  serial read-data bit, LSB first.
- err  output  1  one-cycle pulse on an aborted transaction.

## Operation
- States: IDLE, ADDR, WDATA, WRITE, RLOAD, RSEND.
- IDLE:
  - On valid_in=1, capture address bit 0 and latch wr_en, then go to ADDR.
  - Otherwise stay in IDLE.
- ADDR:
  - Capture address bits 1..ADDR_W-1, one per cycle, into the address shift register.
  - After the last bit, go to WDATA if wr_en was latched 1, otherwise go to RLOAD.
- WDATA: capture DATA_W bits from data_in, one per cycle, then go to WRITE.
- WRITE: write the captured word to mem[addr[MEM_AW-1:0]] at the edge leaving this state, then go to IDLE.
- RLOAD: load mem[addr[MEM_AW-1:0]] into the TX shift register, then go to RSEND.
- RSEND:
  - Drive valid_out=1 and data_out=tx[0]; shift right each cycle.
  - After DATA_W cycles, go to IDLE.
- Address bits above MEM_AW are ignored, so higher addresses alias onto the local memory.
- Abort:
  - valid_in=0 in any cycle of ADDR or WDATA ends the transaction.
  - Response: go to IDLE, pulse err for one cycle, leave the memory unchanged.
- valid_in is don't-care in WRITE, RLOAD and RSEND.
- wr_en is ignored after the start cycle.
- Bit counter: width ceil(log2(max(ADDR_W, DATA_W))), cleared on every state entry.
- Memory contents are not reset; reading an unwritten location returns an undefined value.

## Timing
- Reset (asynchronous assert): state=IDLE, ready=1, valid_out=0, data_out=0, err=0, counters and shift registers cleared.
- T0 = first cycle with valid_in=1 while ready=1. ready falls in T0+1.
- Write (defaults):
  - T0..T11: address bits.
  - T12..T19: data bits.
  - T20: WRITE.
  - T21: IDLE with ready=1.
  - General form: ADDR_W+DATA_W+1 cycles of busy.
- Read (defaults):
  - T0..T11: address bits.
  - T12: RLOAD.
  - T13..T20: valid_out=1 with data bits 0..7.
  - T21: IDLE with ready=1.
- Back-to-back: a new T0 is allowed in the same cycle ready returns to 1.
- Reset mid-transaction:
  - Immediate return to IDLE.
  - valid_out and err drop asynchronously.
  - A pending write is lost.
- err is asserted in the cycle after the sampled valid_in=0; ready=1 in that same cycle.

## Test plan
- Reset, then idle: ready=1, valid_out=0, data_out=0, err=0 held for 10 cycles.
- Write 0xA5 to address 0x005, then read 0x005 → valid_out high T13..T20; data_out = 1,0,1,0,0,1,0,1.
- Aliasing: write 0x3C to address 0x805, then read 0x005 → returns 0x3C.
- Abort: drop valid_in at address bit 6 of a write of 0xFF to 0x010 → err pulse one cycle, ready=1; a subsequent read of 0x010 returns the prior value.
- Back-to-back: a write of 0x11 to 0x001 followed immediately (T21) by a read of 0x001 → 0x11 on data_out with no idle gap.
- Assert reset during RSEND bit 3 → valid_out=0 immediately, ready=1 after release; the next read returns correct data.
